// File: rtl/fsm3_pkg.sv
// Shared types and the 4-state "1-0-1" detector transition function used by
// the channel scheduler.
package fsm3_pkg;

    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } fsm3_state_t;

    // ST_D is the "1-0-1 just seen" state; overlap is natural (D -0-> C -1-> D).
    function automatic fsm3_state_t fsm3_next(input fsm3_state_t state, input logic in_bit);
        fsm3_state_t nxt;
        case (state)
            ST_A:    nxt = in_bit ? ST_B : ST_A;
            ST_B:    nxt = in_bit ? ST_B : ST_C;
            ST_C:    nxt = in_bit ? ST_D : ST_A;
            ST_D:    nxt = in_bit ? ST_B : ST_C;
            default: nxt = ST_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm3_chan_sched_if.sv
// Channel-side request bundle and match reporting of the detector scheduler.
interface fsm3_chan_sched_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    localparam int CHW = $clog2(NCH);

    // Handshake: channel i's bit transfers on a rising edge where
    // req_valid[i] & req_ready[i]; req_ready is one-hot or zero, may depend
    // combinationally on req_valid/chan_clr, and never rises for a channel
    // whose req_valid is low or whose chan_clr is high.
    logic [NCH-1:0]   req_valid;
    logic [NCH-1:0]   req_bit;
    logic [NCH-1:0]   req_ready;
    logic [NCH-1:0]   chan_clr;
    logic             match_valid;
    logic [CHW-1:0]   match_ch;
    logic [CNT_W-1:0] match_count;

    modport master (
        output req_valid, req_bit, chan_clr,
        input  req_ready, match_valid, match_ch, match_count
    );

    modport slave (
        input  req_valid, req_bit, chan_clr,
        output req_ready, match_valid, match_ch, match_count
    );

endinterface

// File: rtl/rr_arbiter_nch.sv
// Combinational round-robin arbiter: grants the first eligible channel above
// ptr, wrapping from NCH-1 back to 0.
module rr_arbiter_nch #(
    parameter int NCH = 4,
    localparam int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] eligible,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] grant_idx,
    output logic           grant_any
);

    logic [CHW:0]   sum;
    logic [CHW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        // k = NCH revisits ptr itself, so a lone requester is never starved.
        for (int k = 1; k <= NCH; k++) begin
            sum = {1'b0, ptr} + (CHW + 1)'(k);
            if (sum >= (CHW + 1)'(NCH)) begin
                sum = sum - (CHW + 1)'(NCH);
            end
            idx = sum[CHW-1:0];
            if (!grant_any && eligible[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/fsm3_chan_sched.sv
// Time-multiplexed "1-0-1" detector: one shared next-state engine serves NCH
// serial channels, one granted bit per cycle, matches tagged by channel.
module fsm3_chan_sched
    import fsm3_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 areset_n,
    fsm3_chan_sched_if.slave     bus,
    output logic [2*NCH-1:0]     dbg_state
);

    localparam int CHW = $clog2(NCH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fsm3_state_t      st_q [NCH];
    fsm3_state_t      st_d [NCH];
    logic [CHW-1:0]   ptr_q, ptr_d;
    logic             mv_q, mv_d;
    logic [CHW-1:0]   mch_q, mch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   grant;
    logic [CHW-1:0]   gidx;
    logic             gany;
    fsm3_state_t      nxt;

    // A channel being cleared is withheld from arbitration for that cycle.
    assign eligible = bus.req_valid & ~bus.chan_clr;

    rr_arbiter_nch #(.NCH(NCH)) u_arb (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (gidx),
        .grant_any (gany)
    );

    assign bus.req_ready   = grant;
    assign bus.match_valid = mv_q;
    assign bus.match_ch    = mch_q;
    assign bus.match_count = cnt_q;

    always_comb begin
        st_d  = st_q;
        ptr_d = ptr_q;
        mv_d  = 1'b0;
        mch_d = mch_q;
        cnt_d = cnt_q;
        nxt   = fsm3_next(st_q[gidx], bus.req_bit[gidx]);

        for (int i = 0; i < NCH; i++) begin
            if (bus.chan_clr[i]) begin
                st_d[i] = ST_A;
            end
        end

        // The granted channel is never the cleared one, so no write conflict.
        if (gany) begin
            st_d[gidx] = nxt;
            ptr_d      = gidx;
            if (nxt == ST_D) begin
                mv_d  = 1'b1;
                mch_d = gidx;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i] <= ST_A;
            end
            ptr_q <= CHW'(NCH - 1);
            mv_q  <= 1'b0;
            mch_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i] <= st_d[i];
            end
            ptr_q <= ptr_d;
            mv_q  <= mv_d;
            mch_q <= mch_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        dbg_state = '0;
        for (int i = 0; i < NCH; i++) begin
            dbg_state[2*i +: 2] = st_q[i];
        end
    end

endmodule

// File: tb/tb_fsm3_chan_sched.sv
// Directed bench for fsm3_chan_sched: a CNT_W=16 instance and a CNT_W=2
// instance see identical stimulus so counter saturation is observable.
module tb_fsm3_chan_sched;

    logic clk;
    logic areset_n;
    logic [7:0] dbg1;
    logic [7:0] dbg2;

    int cmp_cnt;
    int err_cnt;

    fsm3_chan_sched_if #(.NCH(4), .CNT_W(16)) bus1 ();
    fsm3_chan_sched_if #(.NCH(4), .CNT_W(2))  bus2 ();

    assign bus2.req_valid = bus1.req_valid;
    assign bus2.req_bit   = bus1.req_bit;
    assign bus2.chan_clr  = bus1.chan_clr;

    fsm3_chan_sched #(.NCH(4), .CNT_W(16)) dut1 (
        .clk       (clk),
        .areset_n  (areset_n),
        .bus       (bus1),
        .dbg_state (dbg1)
    );

    fsm3_chan_sched #(.NCH(4), .CNT_W(2)) dut2 (
        .clk       (clk),
        .areset_n  (areset_n),
        .bus       (bus2),
        .dbg_state (dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus1.req_valid = '0;
        bus1.req_bit   = '0;
        bus1.chan_clr  = '0;
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        idle_inputs();
        areset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        areset_n = 1'b1;
    endtask

    // One cycle: drive at posedge+1, check grant mid-cycle, check registered
    // outputs at the following posedge+1.
    task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] exp_rdy,
                       input logic exp_mv, input logic [1:0] exp_ch,
                       input logic [15:0] exp_cnt, input logic [1:0] exp_cnt2);
        bus1.req_valid = v;
        bus1.req_bit   = b;
        bus1.chan_clr  = c;
        #2;
        chk({tag, ".rdy"}, 32'(bus1.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".mv"}, 32'(bus1.match_valid), 32'(exp_mv));
        chk({tag, ".mv2"}, 32'(bus2.match_valid), 32'(exp_mv));
        if (exp_mv) begin
            chk({tag, ".ch"}, 32'(bus1.match_ch), 32'(exp_ch));
        end
        chk({tag, ".cnt"}, 32'(bus1.match_count), 32'(exp_cnt));
        chk({tag, ".cnt2"}, 32'(bus2.match_count), 32'(exp_cnt2));
    endtask

    initial begin
        int e_cnt;
        logic exp_mv;
        logic [1:0] e_cnt2;

        cmp_cnt  = 0;
        err_cnt  = 0;
        areset_n = 1'b1;
        idle_inputs();
        #2;

        // reset state and ch0 1,0,1
        do_reset();
        #1;
        chk("rst.rdy", 32'(bus1.req_ready), 32'h0);
        chk("rst.mv", 32'(bus1.match_valid), 32'h0);
        chk("rst.ch", 32'(bus1.match_ch), 32'h0);
        chk("rst.cnt", 32'(bus1.match_count), 32'h0);
        chk("rst.cnt2", 32'(bus2.match_count), 32'h0);
        chk("rst.state", 32'(dbg1), 32'h0);
        cyc("s1.b0", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 16'd0, 2'd0);
        chk("s1.stB", 32'(dbg1[1:0]), 32'd1);
        cyc("s1.b1", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 16'd0, 2'd0);
        chk("s1.stC", 32'(dbg1[1:0]), 32'd2);
        cyc("s1.b2", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 16'd1, 2'd1);
        cyc("s1.idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'd1, 2'd1);

        // ch0 and ch2 competing: grants alternate, including wrap 2 -> 0
        do_reset();
        cyc("s2.c1", 4'b0101, 4'b0101, 4'b0000, 4'b0001, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s2.c2", 4'b0101, 4'b0101, 4'b0000, 4'b0100, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s2.c3", 4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s2.c4", 4'b0101, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s2.c5", 4'b0101, 4'b0101, 4'b0000, 4'b0001, 1'b1, 2'd0, 16'd1, 2'd1);
        cyc("s2.c6", 4'b0101, 4'b0101, 4'b0000, 4'b0100, 1'b1, 2'd2, 16'd2, 2'd2);

        // ch1 overlapping stream 1,0,1,0,1
        do_reset();
        cyc("s3.b0", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s3.b1", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s3.b2", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 16'd1, 2'd1);
        cyc("s3.b3", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 16'd1, 2'd1);
        cyc("s3.b4", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 16'd2, 2'd2);

        // ch3 clear mid-pattern; clearing another channel leaves grant intact
        do_reset();
        cyc("s4.b0", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s4.b1", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0, 16'd0, 2'd0);
        chk("s4.stC", 32'(dbg1[7:6]), 32'd2);
        cyc("s4.clr", 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b0, 2'd0, 16'd0, 2'd0);
        chk("s4.stA", 32'(dbg1[7:6]), 32'd0);
        cyc("s4.b2", 4'b1001, 4'b1000, 4'b0001, 4'b1000, 1'b0, 2'd0, 16'd0, 2'd0);
        chk("s4.stB", 32'(dbg1[7:6]), 32'd1);

        // asynchronous reset between edges with ch0 in C and a match pending
        do_reset();
        cyc("s5.a0", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s5.a1", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s5.b0", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s5.b1", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 16'd0, 2'd0);
        cyc("s5.b2", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 16'd1, 2'd1);
        chk("s5.ch0C", 32'(dbg1[1:0]), 32'd2);
        idle_inputs();
        #1;
        areset_n = 1'b0;
        #1;
        chk("s5.async.mv", 32'(bus1.match_valid), 32'h0);
        chk("s5.async.cnt", 32'(bus1.match_count), 32'h0);
        chk("s5.async.state", 32'(dbg1), 32'h0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        cyc("s5.post", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 16'd0, 2'd0);
        chk("s5.postB", 32'(dbg1[1:0]), 32'd1);

        // 5 overlapping matches on ch1: 16-bit counter 1..5, 2-bit saturates at 3
        do_reset();
        e_cnt = 0;
        for (int k = 0; k < 11; k++) begin
            exp_mv = (k >= 2) && (k % 2 == 0);
            if (exp_mv) e_cnt++;
            e_cnt2 = (e_cnt > 3) ? 2'd3 : 2'(e_cnt);
            cyc("s6", 4'b0010, (k % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0010,
                exp_mv, 2'd1, 16'(e_cnt), e_cnt2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fsm3_chan_sched.md
Name: fsm3_chan_sched

Overview:
- Time-multiplexed scheduler that shares one 4-state "1-0-1" pattern-detector next-state engine among NCH serial bit channels.
- Keeps a 2-bit detector state per channel and arbitrates round-robin among requesting channels, at most one bit per cycle.
- Applies the A/B/C/D transition to the granted channel and reports matches tagged with the channel ID.
- Sits between the channel deserialisers and the event/interrupt logic.

Parameters:
- NCH, 4, number of channels (2..16).
- CHW, $clog2(NCH), channel-ID width (derived; localparam).
- CNT_W, 16, width of the saturating total-match counter.

Ports:
- clk  in  1  clock, rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NCH  per-channel bit valid.
- req_bit  in  NCH  per-channel serial data bit.
- req_ready  out  NCH  one-hot grant; channel i's bit is consumed when req_valid[i] & req_ready[i].
- chan_clr  in  NCH  per-channel synchronous clear of detector state.
- match_valid  out  1  registered one-cycle pulse: a match occurred.
- match_ch  out  CHW  channel ID of the match; valid only with match_valid.
- match_count  out  CNT_W  total matches since reset, saturating.

Behaviour:
- Reset (areset_n=0, asynchronous): all channel states = A, RR pointer = NCH-1 (so channel 0 has first priority), match_valid=0, match_ch=0, match_count=0. req_ready is combinational and 0 while no channel is eligible.
- Per-channel FSM states: A=0, B=1, C=2, D=3.
  - A: in ? B : A
  - B: in ? B : C
  - C: in ? D : A
  - D: in ? B : C
- Eligibility: channel i is eligible when req_valid[i] & ~chan_clr[i].
- Arbitration (combinational, same cycle):
  - Grant the first eligible channel searching from ptr+1 upward, wrapping NCH-1 -> 0.
  - At most one req_ready bit is high.
  - req_ready[i] never rises for a non-eligible channel.
- On accept (rising edge):
  - state[g] <= next(state[g], req_bit[g]).
  - ptr <= g.
  - If next == D: match_valid <= 1 and match_ch <= g next cycle (latency 1 from accept); otherwise match_valid <= 0.
- No accept in a cycle: match_valid <= 0 and ptr holds.
- chan_clr[i]=1: state[i] <= A at the edge; that channel is not granted that cycle. Clears of other channels do not disturb the grant.
- Pattern overlap is inherent: stream 1,0,1,0,1 gives matches on the 3rd and 5th bits (D -in0-> C -in1-> D).
- match_count:
  - Increments by 1 in the same edge that sets match_valid.
  - Holds at 2^CNT_W-1 once reached; no wrap.
- A channel holding req_valid high with no competitors is granted every cycle (full throughput).
- Reset asserted mid-stream: all state is lost immediately; after release, the first accepted bit of any channel is evaluated from state A.
- req_bit of non-granted channels is ignored.

Decomposition:
- Shared package fsm3_pkg:
  - typedef enum logic [1:0] {ST_A, ST_B, ST_C, ST_D} fsm3_state_t.
  - Pure function fsm3_next(state, in) implementing the transition table above.
- One natural sub-module: rr_arbiter_nch.
  - Parameter NCH; inputs eligible vector and ptr; outputs one-hot grant and grant index.
- The state array, pointer, match and counter logic stay in fsm3_chan_sched.

Test Plan:
- Reset then ch0 only, bits 1,0,1 on consecutive cycles -> req_ready=0001 each cycle; match_valid=1 with match_ch=0 exactly one cycle after the 3rd accept; match_count=1.
- ch0 and ch2 both valid continuously, ch0 bits 1,0,1 and ch2 bits 1,0,1 -> grants alternate 0,2,0,2,0,2; match on ch0 after its 3rd accept (cycle 5 accept), ch2 after cycle 6 accept; count=2.
- ch1 stream 1,0,1,0,1 -> two matches (after 3rd and 5th bits), match_ch=1 both times.
- ch3 bits 1,0, then chan_clr[3]=1 with req_valid[3]=1 -> req_ready[3]=0 that cycle; then bit 1 -> no match (state A->B).
- Mid-sequence (ch0 in C) assert areset_n=0 asynchronously between edges -> match_valid, match_count drop to 0 immediately; after release bit 1 on ch0 -> no match.
- CNT_W=2, generate 5 matches -> match_count sequence 1,2,3,3,3; match_valid still pulses for every match.
